data_sram_bridge: RTL and testbench
===================================

// Module: data_sram_bridge
// PURPOSE
//  Data-side bus bridge directly downstream of the MEM stage.
//  - Takes MEM's per-instruction RAM read/write request: word-aligned address, byte-lane select, replicated write data.
//  - Issues exactly one transaction per instruction on an SRAM-like req/addr_ok/data_ok interface.
//  - Returns the raw 32-bit read word to MEM, which does the lane extraction.
//  - Drives data_stall_o into MEM's data_stall_i until the access completes.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in REQ or WAIT before bus error (only with DATA_BRIDGE_TIMEOUT_EN)
// PORTS
//  clk_i               in   1   clock, all state on rising edge
//  reset_i             in   1   asynchronous, active-low reset
//  ram_read_enable_i   in   1   MEM load request
//  ram_read_addr_i     in   32  load address, word-aligned
//  ram_write_enable_i  in   1   MEM store request
//  ram_write_addr_i    in   32  store address, word-aligned
//  ram_write_data_i    in   32  store data, lanes replicated
//  ram_write_select_i  in   4   store byte enables
//  pipeline_stall_i    in   1   a later stage holds the pipeline
//  flush_i             in   1   exception/ERET flush of the MEM instruction
//  ram_read_data_o     out  32  load word returned to MEM
//  data_stall_o        out  1   access outstanding; drives MEM data_stall_i
//  data_sram_req_o     out  1   bus request
//  data_sram_wr_o      out  1   1 = write
//  data_sram_size_o    out  2   0 = byte, 1 = half, 2 = word
//  data_sram_addr_o    out  32  byte address
//  data_sram_wdata_o   out  32  write data
//  data_sram_addr_ok_i in   1   request accepted
//  data_sram_data_ok_i in   1   transaction complete; rdata valid
//  data_sram_rdata_i   in   32  read data
//  bus_error_o         out  1   one-cycle timeout pulse (macro only; else tied 0)
// BEHAVIOUR
//  Reset (reset_i = 0, async):
//   - state = IDLE; all outputs 0 (including ram_read_data_o); request registers cleared.
//  Access decode:
//   - wr = ram_write_enable_i && select != 0; rd = ram_read_enable_i && !wr. Write wins if both.
//   - access = wr || rd.
//  Write size/address from select:
//   - 0001/0010/0100/1000 -> size 0, addr[1:0] = 0/1/2/3.
//   - 0011 -> size 1, addr[1:0] = 0; 1100 -> size 1, addr[1:0] = 2.
//   - 1111 -> size 2, addr[1:0] = 0.
//   - Any other select -> size 2, addr[1:0] = 0, wstrb as given.
//  Reads: size 2, address passed unchanged.
//  FSM:
//   - IDLE: access && !flush_i -> latch wr/size/addr/wdata -> REQ. Otherwise stay.
//   - REQ: data_sram_req_o = 1; req/wr/size/addr/wdata held stable until addr_ok.
//       flush_i && !addr_ok -> IDLE (request withdrawn).
//       addr_ok && data_ok in the same cycle -> DONE (rdata latched).
//       addr_ok only -> WAIT.
//   - WAIT: req = 0. data_ok -> DONE and latch rdata into ram_read_data_o.
//       flush_i seen in WAIT -> CANCEL.
//   - CANCEL: waits for data_ok, discards rdata -> IDLE. No new request is issued while in CANCEL.
//   - DONE: holds ram_read_data_o.
//       !pipeline_stall_i || flush_i -> IDLE, so the next instruction is seen on the following cycle.
//  data_stall_o:
//   - IDLE: = access && !flush_i (combinational).
//   - REQ, WAIT, CANCEL: 1.
//   - DONE: 0.
//  Latency with zero-wait slave (addr_ok and data_ok in first REQ cycle):
//   - Access seen in cycle 0; req in cycle 1; data registered in cycle 2 (DONE).
//   - Stall high in cycles 0-1.
//   - Each extra slave wait cycle adds one stall cycle.
//  ram_read_data_o changes only on the data_ok capture in WAIT, or on addr_ok && data_ok in REQ; it also updates for writes.
//  A spurious data_ok in IDLE or DONE is ignored.
// CONFIGURATION
//  DATA_BRIDGE_TIMEOUT_EN defined:
//   - 8-bit-min cycle counter cleared on entry to REQ and at each addr_ok.
//   - Reaching TIMEOUT_CYCLES in REQ, WAIT or CANCEL -> bus_error_o pulse for 1 cycle, state -> IDLE.
//   - A timeout in REQ or WAIT also forces ram_read_data_o = 32'h0.
//  Not defined: no counter; bus_error_o tied 0; FSM waits forever.
// TESTING
//  - LW addr 0x1000, slave addr_ok and data_ok in first REQ cycle, rdata 0xDEADBEEF -> stall 2 cycles, ram_read_data_o = 0xDEADBEEF in DONE, one req.
//  - SB select 0100, addr 0x2000, data 0x5A5A5A5A -> data_sram_addr_o = 0x2002, size 0, wr 1, wdata 0x5A5A5A5A.
//  - SH select 1100 with addr_ok delayed 3 cycles -> addr 0x..2, size 1, req/addr held 4 cycles, stall released only in DONE.
//  - flush_i in WAIT, data_ok 2 cycles later -> CANCEL, rdata discarded, no second req, stall low after return to IDLE.
//  - DONE with pipeline_stall_i = 1 for 3 cycles -> stays DONE, data held, no new req; then IDLE.
//  - reset_i low mid-WAIT -> outputs 0 immediately (async); with macro, no data_ok for 255 cycles -> bus_error_o one-cycle pulse.

Source files
------------

// File: rtl/data_sram_bridge.sv
// MEM-side data bridge: one SRAM-like req/addr_ok/data_ok transaction per load/store; bus timeout under DATA_BRIDGE_TIMEOUT_EN.
// Latency: request one cycle after MEM presents it, data registered one cycle after data_ok (2 cycles with a zero-wait slave).
// Backpressure: data_stall_o holds MEM until DONE; each addr_ok/data_ok wait cycle adds one stall cycle.
module data_sram_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ram_read_enable_i,
  input  logic [31:0] ram_read_addr_i,
  input  logic        ram_write_enable_i,
  input  logic [31:0] ram_write_addr_i,
  input  logic [31:0] ram_write_data_i,
  input  logic [3:0]  ram_write_select_i,
  input  logic        pipeline_stall_i,
  input  logic        flush_i,
  output logic [31:0] ram_read_data_o,
  output logic        data_stall_o,
  output logic        data_sram_req_o,
  output logic        data_sram_wr_o,
  output logic [1:0]  data_sram_size_o,
  output logic [31:0] data_sram_addr_o,
  output logic [31:0] data_sram_wdata_o,
  input  logic        data_sram_addr_ok_i,
  input  logic        data_sram_data_ok_i,
  input  logic [31:0] data_sram_rdata_i,
  output logic        bus_error_o
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CANCEL, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        tmo_fire;
  logic        timeout;

  logic        acc_wr, acc_rd, access, busy;
  logic [1:0]  wr_size, wr_off, acc_size;
  logic [31:0] acc_addr;
  logic        unused_addr_lsb;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  assign acc_wr          = ram_write_enable_i && (ram_write_select_i != 4'b0000);
  assign acc_rd          = ram_read_enable_i && !acc_wr;
  assign access          = acc_wr || acc_rd;
  assign busy            = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_CANCEL);
  assign unused_addr_lsb = ^ram_write_addr_i[1:0];

  // Byte-lane select maps to bus size and the low address bits; odd patterns fall back to a word access.
  always_comb begin
    wr_size = 2'd2;
    wr_off  = 2'd0;
    case (ram_write_select_i)
      4'b0001: begin wr_size = 2'd0; wr_off = 2'd0; end
      4'b0010: begin wr_size = 2'd0; wr_off = 2'd1; end
      4'b0100: begin wr_size = 2'd0; wr_off = 2'd2; end
      4'b1000: begin wr_size = 2'd0; wr_off = 2'd3; end
      4'b0011: begin wr_size = 2'd1; wr_off = 2'd0; end
      4'b1100: begin wr_size = 2'd1; wr_off = 2'd2; end
      default: ;
    endcase
  end

  assign acc_size = acc_wr ? wr_size : 2'd2;
  assign acc_addr = acc_wr ? {ram_write_addr_i[31:2], wr_off} : ram_read_addr_i;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    tmo_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && !flush_i) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          wr_d    = acc_wr;
          size_d  = acc_size;
          addr_d  = acc_addr;
          wdata_d = ram_write_data_i;
        end
      end
      S_REQ: begin
        if (data_sram_addr_ok_i) begin
          req_d = 1'b0;
          // Once accepted the slave owes a data_ok, so a flush only decides whether the result is kept.
          if (data_sram_data_ok_i) begin
            if (flush_i) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DONE;
              rdata_d = data_sram_rdata_i;
            end
          end else begin
            state_d = flush_i ? S_CANCEL : S_WAIT;
          end
        end else if (flush_i) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end else if (timeout) begin
          state_d  = S_IDLE;
          req_d    = 1'b0;
          rdata_d  = '0;
          tmo_fire = 1'b1;
        end
      end
      S_WAIT: begin
        if (data_sram_data_ok_i) begin
          if (flush_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            rdata_d = data_sram_rdata_i;
          end
        end else if (flush_i) begin
          state_d = S_CANCEL;
        end else if (timeout) begin
          state_d  = S_IDLE;
          rdata_d  = '0;
          tmo_fire = 1'b1;
        end
      end
      S_CANCEL: begin
        if (data_sram_data_ok_i) begin
          state_d = S_IDLE;
        end else if (timeout) begin
          state_d  = S_IDLE;
          tmo_fire = 1'b1;
        end
      end
      S_DONE: begin
        if (!pipeline_stall_i || flush_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef DATA_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_error_q;

  assign timeout = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!busy || ((state_q == S_REQ) && data_sram_addr_ok_i)) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bus_error_q <= tmo_fire;
    end
  end

  assign bus_error_o = bus_error_q;
`else
  logic unused_tmo;

  assign timeout     = 1'b0;
  assign unused_tmo  = tmo_fire ^ busy;
  assign bus_error_o = 1'b0;
`endif

  assign data_sram_req_o   = req_q;
  assign data_sram_wr_o    = wr_q;
  assign data_sram_size_o  = size_q;
  assign data_sram_addr_o  = addr_q;
  assign data_sram_wdata_o = wdata_q;
  assign ram_read_data_o   = rdata_q;
  assign data_stall_o      = reset_i && ((state_q == S_IDLE) ? (access && !flush_i)
                                                               : (state_q != S_DONE));

endmodule

// File: tb/tb_data_sram_bridge.sv
// Bench for data_sram_bridge: vector table, directed flush/reset corners and random
// transactions scored against transaction-level expectations.
module tb_data_sram_bridge;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ram_read_enable_i;
  logic [31:0] ram_read_addr_i;
  logic        ram_write_enable_i;
  logic [31:0] ram_write_addr_i;
  logic [31:0] ram_write_data_i;
  logic [3:0]  ram_write_select_i;
  logic        pipeline_stall_i;
  logic        flush_i;
  logic [31:0] ram_read_data_o;
  logic        data_stall_o;
  logic        data_sram_req_o;
  logic        data_sram_wr_o;
  logic [1:0]  data_sram_size_o;
  logic [31:0] data_sram_addr_o;
  logic [31:0] data_sram_wdata_o;
  logic        data_sram_addr_ok_i;
  logic        data_sram_data_ok_i;
  logic [31:0] data_sram_rdata_i;
  logic        bus_error_o;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_rdata = 32'h0;

  always #5 clk_i = ~clk_i;

  data_sram_bridge dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .ram_read_enable_i   (ram_read_enable_i),
    .ram_read_addr_i     (ram_read_addr_i),
    .ram_write_enable_i  (ram_write_enable_i),
    .ram_write_addr_i    (ram_write_addr_i),
    .ram_write_data_i    (ram_write_data_i),
    .ram_write_select_i  (ram_write_select_i),
    .pipeline_stall_i    (pipeline_stall_i),
    .flush_i             (flush_i),
    .ram_read_data_o     (ram_read_data_o),
    .data_stall_o        (data_stall_o),
    .data_sram_req_o     (data_sram_req_o),
    .data_sram_wr_o      (data_sram_wr_o),
    .data_sram_size_o    (data_sram_size_o),
    .data_sram_addr_o    (data_sram_addr_o),
    .data_sram_wdata_o   (data_sram_wdata_o),
    .data_sram_addr_ok_i (data_sram_addr_ok_i),
    .data_sram_data_ok_i (data_sram_data_ok_i),
    .data_sram_rdata_i   (data_sram_rdata_i),
    .bus_error_o         (bus_error_o)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          a_w;
    int          d_w;
    int          hold;
    logic [31:0] rword;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr;
    int          exp_stall;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    ram_read_enable_i   = 1'b0;
    ram_read_addr_i     = 32'h0;
    ram_write_enable_i  = 1'b0;
    ram_write_addr_i    = 32'h0;
    ram_write_data_i    = 32'h0;
    ram_write_select_i  = 4'h0;
    pipeline_stall_i    = 1'b0;
    flush_i             = 1'b0;
    data_sram_addr_ok_i = 1'b0;
    data_sram_data_ok_i = 1'b0;
    data_sram_rdata_i   = 32'h0;
  endtask

  // Lane select -> bus size / byte offset, straight from the select encoding rules.
  function automatic void mdl_lane(input logic [3:0] sel, output logic [1:0] sz, output logic [1:0] off);
    sz  = 2'd2;
    off = 2'd0;
    if ($countones(sel) == 1) begin
      sz = 2'd0;
      for (int i = 0; i < 4; i++) if (sel[i]) off = 2'(i);
    end else if (sel == 4'b0011) begin
      sz = 2'd1;
    end else if (sel == 4'b1100) begin
      sz  = 2'd1;
      off = 2'd2;
    end
  endfunction

  // Plays MEM and a slave with a_w addr_ok waits and d_w data_ok waits; scores whole-transaction counts.
  task automatic do_txn(input vec_t v, input string tag);
    int req_cycles   = 0;
    int wcnt         = 0;
    int stall_cycles = 0;
    int done_cnt     = 0;
    int extra_req    = 0;
    int ret_cyc      = -1;
    int budget;
    bit accepted     = 1'b0;
    bit acc_prev     = 1'b0;
    bit returned     = 1'b0;
    bit finished     = 1'b0;
    budget = v.a_w + v.d_w + v.hold + 12;
    ram_read_enable_i  = v.re;
    ram_read_addr_i    = v.raddr;
    ram_write_enable_i = v.we;
    ram_write_addr_i   = v.waddr;
    ram_write_data_i   = v.wdata;
    ram_write_select_i = v.sel;
    flush_i            = 1'b0;
    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      bit in_done;
      in_done             = returned && (cyc > ret_cyc);
      data_sram_addr_ok_i = 1'b0;
      data_sram_data_ok_i = 1'b0;
      data_sram_rdata_i   = $urandom;
      pipeline_stall_i    = 1'($urandom_range(0, 1));
      if (in_done) begin
        pipeline_stall_i    = (done_cnt < v.hold);
        done_cnt++;
        data_sram_data_ok_i = 1'($urandom_range(0, 1));
      end else if (data_sram_req_o && !accepted) begin
        req_cycles++;
        if (req_cycles == v.a_w + 1) begin
          data_sram_addr_ok_i = 1'b1;
          accepted            = 1'b1;
          if (v.d_w == 0) begin
            data_sram_data_ok_i = 1'b1;
            data_sram_rdata_i   = v.rword;
            returned            = 1'b1;
            ret_cyc             = cyc;
          end
        end
      end else if (accepted && !returned) begin
        wcnt++;
        if (wcnt == v.d_w) begin
          data_sram_data_ok_i = 1'b1;
          data_sram_rdata_i   = v.rword;
          returned            = 1'b1;
          ret_cyc             = cyc;
        end
      end
      #3;
      if (data_stall_o) stall_cycles++;
      if (data_sram_req_o && acc_prev) extra_req++;
      if (data_sram_req_o && !acc_prev) begin
        chk({tag, "_addr"}, data_sram_addr_o, v.exp_addr);
        chk({tag, "_size"}, 32'(data_sram_size_o), 32'(v.exp_size));
        chk({tag, "_wr"}, 32'(data_sram_wr_o), 32'(v.exp_wr));
        if (v.exp_wr) chk({tag, "_wdata"}, data_sram_wdata_o, v.wdata);
      end
      if (in_done) begin
        chk({tag, "_done_rdata"}, ram_read_data_o, v.rword);
        if (!pipeline_stall_i) finished = 1'b1;
      end
      acc_prev = accepted;
      step();
    end
    chk({tag, "_completed"}, 32'(finished), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(v.exp_stall));
    chk({tag, "_req_cycles"}, 32'(req_cycles), 32'(v.a_w + 1));
    chk({tag, "_extra_req"}, 32'(extra_req), 32'd0);
    idle_inputs();
    #3;
    chk({tag, "_idle_stall"}, 32'(data_stall_o), 32'd0);
    chk({tag, "_idle_req"}, 32'(data_sram_req_o), 32'd0);
    chk({tag, "_idle_rdata"}, ram_read_data_o, v.rword);
    exp_rdata = v.rword;
    step();
  endtask

  initial begin
    vec_t v;
    logic [1:0] sz, off;

    //            we    re    raddr         waddr         wdata         sel      a  d  h  rword         ewr   esz   eaddr         stall
    tbl[0] = '{1'b0, 1'b1, 32'h0000_1000, 32'h0,        32'h0,        4'b0000, 0, 0, 0, 32'hDEAD_BEEF, 1'b0, 2'd2, 32'h0000_1000, 2};
    tbl[1] = '{1'b1, 1'b0, 32'h0,        32'h0000_2000, 32'h5A5A_5A5A, 4'b0100, 0, 1, 0, 32'h1111_2222, 1'b1, 2'd0, 32'h0000_2002, 3};
    tbl[2] = '{1'b1, 1'b0, 32'h0,        32'h0000_3000, 32'hA5A5_1234, 4'b1100, 3, 0, 1, 32'h3333_4444, 1'b1, 2'd1, 32'h0000_3002, 5};
    tbl[3] = '{1'b0, 1'b1, 32'h0000_4004, 32'h0,        32'h0,        4'b0000, 1, 2, 3, 32'hCAFE_F00D, 1'b0, 2'd2, 32'h0000_4004, 5};
    tbl[4] = '{1'b1, 1'b0, 32'h0,        32'h0000_5008, 32'h0123_4567, 4'b1111, 0, 0, 0, 32'h5555_6666, 1'b1, 2'd2, 32'h0000_5008, 2};
    tbl[5] = '{1'b1, 1'b0, 32'h0,        32'h0000_6000, 32'h7777_7777, 4'b1000, 2, 1, 0, 32'h7777_8888, 1'b1, 2'd0, 32'h0000_6003, 5};
    tbl[6] = '{1'b1, 1'b0, 32'h0,        32'h0000_7004, 32'h9999_BEEF, 4'b0011, 0, 0, 2, 32'h9999_AAAA, 1'b1, 2'd1, 32'h0000_7004, 2};
    tbl[7] = '{1'b1, 1'b1, 32'h0000_9000, 32'h0000_8000, 32'h0000_00C3, 4'b0001, 1, 0, 0, 32'hBBBB_CCCC, 1'b1, 2'd0, 32'h0000_8000, 3};
    tbl[8] = '{1'b1, 1'b1, 32'h0000_A000, 32'h0000_A100, 32'h1234_0000, 4'b0000, 0, 0, 0, 32'hDDDD_EEEE, 1'b0, 2'd2, 32'h0000_A000, 2};
    tbl[9] = '{1'b1, 1'b0, 32'h0,        32'h0000_B004, 32'hF0F0_0F0F, 4'b0101, 0, 3, 0, 32'h0F0F_F0F0, 1'b1, 2'd2, 32'h0000_B004, 5};

    // Reset with a pending MEM access: every output must stay low.
    idle_inputs();
    reset_i            = 1'b0;
    ram_read_enable_i  = 1'b1;
    ram_write_enable_i = 1'b1;
    ram_write_select_i = 4'hF;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_stall", 32'(data_stall_o), 32'd0);
    chk("rst_req", 32'(data_sram_req_o), 32'd0);
    chk("rst_wr", 32'(data_sram_wr_o), 32'd0);
    chk("rst_size", 32'(data_sram_size_o), 32'd0);
    chk("rst_addr", data_sram_addr_o, 32'h0);
    chk("rst_wdata", data_sram_wdata_o, 32'h0);
    chk("rst_rdata", ram_read_data_o, 32'h0);
    chk("rst_bus_error", 32'(bus_error_o), 32'd0);
    reset_i = 1'b1;
    idle_inputs();
    step();

    for (int i = 0; i < 10; i++) do_txn(tbl[i], $sformatf("tbl%0d", i));

    // Flush while waiting for data: CANCEL swallows the late data_ok and issues nothing new.
    ram_read_enable_i = 1'b1;
    ram_read_addr_i   = 32'h0000_4000;
    #3; chk("fw_c0_stall", 32'(data_stall_o), 32'd1);
    chk("fw_c0_req", 32'(data_sram_req_o), 32'd0);
    step();
    data_sram_addr_ok_i = 1'b1;
    #3; chk("fw_c1_req", 32'(data_sram_req_o), 32'd1);
    step();
    data_sram_addr_ok_i = 1'b0;
    flush_i             = 1'b1;
    #3; chk("fw_wait_req", 32'(data_sram_req_o), 32'd0);
    chk("fw_wait_stall", 32'(data_stall_o), 32'd1);
    step();
    flush_i            = 1'b0;
    ram_write_enable_i = 1'b1;
    ram_write_addr_i   = 32'h0000_4100;
    ram_write_select_i = 4'hF;
    #3; chk("fw_cancel_req", 32'(data_sram_req_o), 32'd0);
    chk("fw_cancel_stall", 32'(data_stall_o), 32'd1);
    step();
    idle_inputs();
    data_sram_data_ok_i = 1'b1;
    data_sram_rdata_i   = 32'hBAD0_BAD0;
    #3; chk("fw_cancel2_req", 32'(data_sram_req_o), 32'd0);
    chk("fw_cancel2_stall", 32'(data_stall_o), 32'd1);
    step();
    data_sram_data_ok_i = 1'b0;
    #3; chk("fw_idle_stall", 32'(data_stall_o), 32'd0);
    chk("fw_idle_req", 32'(data_sram_req_o), 32'd0);
    chk("fw_idle_rdata", ram_read_data_o, exp_rdata);
    step();

    // Flush before addr_ok withdraws the request.
    ram_read_enable_i = 1'b1;
    ram_read_addr_i   = 32'h0000_4200;
    #3; step();
    ram_read_enable_i = 1'b0;
    flush_i           = 1'b1;
    #3; chk("fr_req_up", 32'(data_sram_req_o), 32'd1);
    step();
    flush_i = 1'b0;
    #3; chk("fr_req_down", 32'(data_sram_req_o), 32'd0);
    chk("fr_stall", 32'(data_stall_o), 32'd0);
    step();

    // Stray data_ok while idle.
    data_sram_data_ok_i = 1'b1;
    data_sram_rdata_i   = 32'h1234_5678;
    #3; step();
    data_sram_data_ok_i = 1'b0;
    #3; chk("spurious_rdata", ram_read_data_o, exp_rdata);
    chk("spurious_req", 32'(data_sram_req_o), 32'd0);
    step();

    for (int i = 0; i < 40; i++) begin
      v.we = 1'($urandom_range(0, 1));
      if (v.we) begin
        v.sel = 4'($urandom_range(1, 15));
        v.re  = 1'($urandom_range(0, 1));
      end else begin
        v.sel = 4'($urandom_range(0, 15));
        v.re  = 1'b1;
      end
      v.raddr = $urandom & 32'hFFFF_FFFC;
      v.waddr = $urandom & 32'hFFFF_FFFC;
      v.wdata = $urandom;
      v.a_w   = $urandom_range(0, 3);
      v.d_w   = $urandom_range(0, 3);
      v.hold  = $urandom_range(0, 2);
      v.rword = $urandom;
      mdl_lane(v.sel, sz, off);
      v.exp_wr    = v.we;
      v.exp_size  = v.we ? sz : 2'd2;
      v.exp_addr  = v.we ? {v.waddr[31:2], off} : v.raddr;
      v.exp_stall = v.a_w + 2 + v.d_w;
      do_txn(v, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of WAIT.
    ram_read_enable_i = 1'b1;
    ram_read_addr_i   = 32'h0000_4300;
    #3; step();
    data_sram_addr_ok_i = 1'b1;
    #3; step();
    data_sram_addr_ok_i = 1'b0;
    #3; chk("rw_wait_stall", 32'(data_stall_o), 32'd1);
    reset_i = 1'b0;
    #1;
    chk("rw_stall", 32'(data_stall_o), 32'd0);
    chk("rw_req", 32'(data_sram_req_o), 32'd0);
    chk("rw_addr", data_sram_addr_o, 32'h0);
    chk("rw_size", 32'(data_sram_size_o), 32'd0);
    chk("rw_rdata", ram_read_data_o, 32'h0);
    chk("rw_wdata", data_sram_wdata_o, 32'h0);
    step();
    step();
    reset_i = 1'b1;
    idle_inputs();
    exp_rdata = 32'h0;
    step();
    do_txn(tbl[0], "post_reset");

`ifdef DATA_BRIDGE_TIMEOUT_EN
    begin
      int pulses;
      pulses            = 0;
      ram_read_enable_i = 1'b1;
      ram_read_addr_i   = 32'h0000_4400;
      #3; step();
      data_sram_addr_ok_i = 1'b1;
      #3; step();
      idle_inputs();
      for (int c = 0; c < 300; c++) begin
        #3;
        if (bus_error_o) pulses++;
        step();
      end
      chk("tmo_pulses", 32'(pulses), 32'd1);
      chk("tmo_rdata", ram_read_data_o, 32'h0);
      chk("tmo_stall", 32'(data_stall_o), 32'd0);
      exp_rdata = 32'h0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
